// File: rtl/mul_pkg.sv
// Shared definitions for the shift-add multiplier: FSM state type and default width.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mul_pkg;

  // Default operand width; the product is twice this wide.
  localparam int MUL_WIDTH_DEF = 4;

  // Multiplier control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_add_stage.sv
// WIDTH-bit ripple-carry adder built from a chain of full-adder cells.
// Latency: combinational, 0 cycles.
// Backpressure: none (pure function of its inputs).
//
// Ports:
//   x, y  : WIDTH-bit addends
//   cin   : carry into bit 0
//   s     : WIDTH-bit sum
//   cout  : carry out of the top bit
module mul_add_stage
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  // c[i] is the carry into bit i; c[WIDTH] leaves the top cell.
  logic [WIDTH:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
  end

  assign cout = c[WIDTH];

endmodule

// File: rtl/shift_add_mul.sv
// Sequential unsigned multiplier: one shift-add step per cycle, one job at a time.
// Latency: out_valid rises WIDTH+1 edges after acceptance (counting the accepting edge);
//          with MUL_ZERO_BYPASS_EN a zero operand goes straight to DONE (1 edge).
// Backpressure: product and out_valid hold in DONE until out_ready; in_ready is low
//          from acceptance until one cycle after the handoff.
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake, a (multiplicand) and b (multiplier)
//   out_valid / out_ready: product handshake
//   product              : 2*WIDTH-bit registered result, = {hi, mplier}
// Optional feature macro: MUL_ZERO_BYPASS_EN (zero-operand shortcut).
module shift_add_mul
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  mul_state_t       state, state_nxt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] hi;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             zero_op;
  logic             last_step;

`ifdef MUL_ZERO_BYPASS_EN
  assign zero_op = (a == '0) || (b == '0);
`else
  assign zero_op = 1'b0;
`endif

  // The counter reaches WIDTH-1 on the final RUN cycle, so it never wraps.
  assign last_step = (cnt == CW'(WIDTH - 1));

  // Partial product for this step: add the multiplicand only when the
  // current multiplier LSB is set.
  assign addend = mplier[0] ? mcand : '0;

  mul_add_stage #(.WIDTH(WIDTH)) u_add (
    .x   (hi),
    .y   (addend),
    .cin (1'b0),
    .s   (sum),
    .cout(carry)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. in_valid is only looked at in IDLE, so a handoff in
  // DONE can never overlap with a new acceptance.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = zero_op ? DONE : RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state only.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath. The accumulator {hi, mplier} shifts right each step: the new
  // sum bits enter at the top while consumed multiplier bits drop out the
  // bottom, leaving the full product in place after WIDTH steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      hi     <= '0;
      cnt    <= '0;
    end else if (state == IDLE && in_valid) begin
      mcand  <= a;
      mplier <= zero_op ? '0 : b;
      hi     <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      hi     <= {carry, sum[WIDTH-1:1]};
      mplier <= {sum[0], mplier[WIDTH-1:1]};
      cnt    <= cnt + 1'b1;
    end
  end

  assign product = {hi, mplier};

endmodule

// File: tb/tb_shift_add_mul.sv
// Self-checking bench for shift_add_mul (WIDTH=4): directed jobs, reset abort,
// continuous in_valid, and a full operand sweep with random output stalls.
// Expected products are queued on acceptance and compared at each handoff.
module tb_shift_add_mul;

  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;

  int checks   = 0;
  int failures = 0;
  int acc_cnt  = 0;
  int hand_cnt = 0;
  logic [2*W-1:0] exp_q[$];

  shift_add_mul #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push a*b on every accepting edge, pop and compare on every handoff.
  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      exp_q.push_back({4'b0, a} * {4'b0, b});
      acc_cnt++;
    end
    if (rst_n && out_valid && out_ready) begin
      hand_cnt++;
      chk("sb_has_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("sb_product", 32'(product), 32'(exp_q.pop_front()));
    end
  end

  function automatic int exp_latency(input logic [W-1:0] ta, input logic [W-1:0] tb_);
`ifdef MUL_ZERO_BYPASS_EN
    if (ta == 0 || tb_ == 0) return 1;
`endif
    return W + 1;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_in_ready", 32'(in_ready), 32'd1);
  endtask

  // One complete job: accept, measure latency, stall in DONE, hand off.
  task automatic job(input logic [W-1:0] ta, input logic [W-1:0] tb_, input int stall);
    int lat;
    logic [2*W-1:0] expp;
    expp = {4'b0, ta} * {4'b0, tb_};
    wait_ready();
    a = ta; b = tb_; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_latency(ta, tb_)));
    for (int i = 0; i < stall; i++) begin
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_product", 32'(product), 32'(expp));
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_handoff_in_ready", 32'(in_ready), 32'd1);
    chk("post_handoff_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic saw_valid;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #3;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_product", 32'(product), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Max operands.
    job(4'd15, 4'd15, 0);
    // Held in DONE for five cycles.
    job(4'd6, 4'd7, 5);
    // Zero operand.
    job(4'd0, 4'd9, 0);

    // Reset during the second RUN cycle aborts the job.
    wait_ready();
    a = 4'd8; b = 4'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_product", 32'(product), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    acc_cnt = acc_cnt - exp_q.size();
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    saw_valid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    out_ready = 1'b0;
    chk("abort_no_output", 32'(saw_valid), 32'd0);
    job(4'd3, 4'd5, 0);

    // in_valid held high across two back-to-back jobs.
    wait_ready();
    n = acc_cnt;
    a = 4'd2; b = 4'd3; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("hold_first_product", 32'(product), 32'h06);
    a = 4'd4; b = 4'd4;
    @(posedge clk); #1;
    chk("hold_idle_in_ready", 32'(in_ready), 32'd1);
    chk("hold_idle_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("hold_second_product", 32'(product), 32'h10);
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hold_accept_count", 32'(acc_cnt - n), 32'd2);

    // Every operand pair with random output stalls.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        job(W'(ia), W'(ib), $urandom_range(0, 3));
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    chk("handoffs_eq_accepts", 32'(hand_cnt), 32'(acc_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_add_mul.md
SHIFT_ADD_MUL -- requirements
Module: shift_add_mul

Interface
REQ-001 Parameter: WIDTH, default 4, operand width; product width is 2*WIDTH.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  1  operand pair present.
REQ-005 Port: in_ready  output  1  block can accept an operand pair.
REQ-006 Port: a  input  WIDTH  multiplicand, unsigned.
REQ-007 Port: b  input  WIDTH  multiplier, unsigned.
REQ-008 Port: out_valid  output  1  product available.
REQ-009 Port: out_ready  input  1  downstream accepts product.
REQ-010 Port: product  output  2*WIDTH  unsigned a*b; registered.

Function
REQ-011 The block SHALL implement an FSM with states IDLE, RUN, DONE; state encoding is registered.
REQ-012 IDLE: in_ready=1; in_valid=1 SHALL capture a into mcand and b into mplier, clear hi to 0 and the cycle counter to 0, and move to RUN; a and b are sampled only on that edge.
REQ-013 RUN: each cycle SHALL compute {c,sum}=hi+(mplier[0]?mcand:0) with a WIDTH-bit adder plus carry-out, then shift {c,sum,mplier} right by one into {hi,mplier}, and increment the counter.
REQ-014 RUN SHALL last exactly WIDTH cycles; after the WIDTH-th RUN edge the state is DONE with product={hi,mplier}.
REQ-015 Latency: out_valid SHALL rise WIDTH+1 edges after the accepting edge (5 for WIDTH=4).
REQ-016 DONE: out_valid=1 and product SHALL hold stable until out_ready=1; that edge returns to IDLE.
REQ-017 in_ready SHALL be 0 in RUN and DONE; no acceptance in the same cycle as a product handoff (one idle cycle minimum between jobs).
REQ-018 in_valid in RUN/DONE SHALL be ignored; in_valid/out_ready both high in DONE SHALL complete the handoff only.
REQ-019 Arithmetic SHALL be exact: no overflow possible; max case (2^WIDTH-1)^2 fits 2*WIDTH bits.
REQ-020 Counter width SHALL be clog2(WIDTH+1) bits; no wrap-around reachable.

Reset
REQ-021 rst_n=0 SHALL immediately force state=IDLE, in_ready=1, out_valid=0, product=0, hi/mplier/mcand/counter=0.
REQ-022 Reset asserted mid-RUN or in DONE SHALL abort the job; the pending product is discarded, with no output afterward.
REQ-023 After rst_n deasserts, the first rising edge with in_valid=1 SHALL be accepted.

Configuration
REQ-024 Macro MUL_ZERO_BYPASS_EN, when defined: acceptance with a==0 or b==0 SHALL go directly to DONE with product=0, giving out_valid 1 edge after acceptance.
REQ-025 Without MUL_ZERO_BYPASS_EN: zero operands SHALL take the full WIDTH-cycle RUN path; the result is identical and the latency is WIDTH+1.

Structure
REQ-026 A shared package mul_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and the default width constant MUL_WIDTH_DEF=4.
REQ-027 The per-cycle addition SHALL be a sub-module mul_add_stage: combinational WIDTH-bit ripple adder, inputs x,y,cin, outputs s,cout; built from a full-adder cell chain.
REQ-028 There is no other sub-module, and no combinational path from inputs to product.

Verification
REQ-029 a=15,b=15, out_ready=1 -> out_valid 5 edges after accept, product=0xE1 (225).
REQ-030 a=6,b=7; out_ready held 0 for 5 cycles in DONE -> product=0x2A stable, out_valid=1 throughout; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-031 a=0,b=9 -> product=0x00; latency 1 with MUL_ZERO_BYPASS_EN, 5 without.
REQ-032 a=8,b=1 accepted, rst_n pulsed low on 2nd RUN cycle -> out_valid=0, product=0 immediately; no out_valid follows; next job a=3,b=5 -> 0x0F.
REQ-033 in_valid held high continuously with a=2,b=3 then a=4,b=4 -> exactly one accept per job, products 0x06 then 0x10, jobs separated by at least one IDLE cycle.
REQ-034 Exhaustive sweep of all 256 (a,b) pairs with random out_ready stalls -> every product equals a*b; zero lost or duplicated.
